// File: rtl/addr_nu_serial_dmr.sv
// addr_nu_serial_dmr
// Digit-serial unsigned adder with a duplicated (primary/shadow) datapath.
// Each attempt adds the captured operands DIGIT bits per cycle, LSB first,
// in two independent copies. The copies are compared at the end. On a
// disagreement the addition is repeated up to MAX_RETRY times. If no
// attempt agrees, the primary result is delivered with fault set.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair a/b valid
//   in_ready   block can accept operands (idle and not in reset)
//   a, b       WIDTH-bit unsigned operands
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   sum        WIDTH+1-bit result, carry-out in the MSB
//   fault      primary and shadow disagreed on every attempt
//   retries    number of re-computations used for this result
//   inj_en     fault-injection hook, flips bit 0 of the shadow digit sum in RUN
`timescale 1ns/1ps

module addr_nu_serial_dmr #(
    parameter int WIDTH     = 32'sd4,
    parameter int DIGIT     = 32'sd1,
    parameter int MAX_RETRY = 32'sd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             fault,
    output logic [2:0]       retries,
    input  logic             inj_en
);

    if ((WIDTH < 32'sd2) || (DIGIT < 32'sd1) || ((WIDTH % DIGIT) != 32'sd0) ||
        (MAX_RETRY < 32'sd0) || (MAX_RETRY > 32'sd7)) begin : g_bad_param
        $error("addr_nu_serial_dmr: illegal WIDTH/DIGIT/MAX_RETRY combination");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 32'sd1) ? $clog2(N) : 32'sd1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 32'sd1);
    localparam logic [2:0]    MAX_R    = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // One digit of addition: DIGIT-bit sum plus carry-out in the top bit.
    function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                                 input logic [DIGIT-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    cnt_r;
    logic             c_p_r;
    logic             c_s_r;
    logic [WIDTH:0]   ps_p_r;
    logic [WIDTH:0]   ps_s_r;
    logic [WIDTH:0]   sum_r;
    logic             fault_r;
    logic [2:0]       retries_r;
    logic             out_valid_r;

    logic [31:0]      shamt_s;
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT:0]   dsum_p_s;
    logic [DIGIT:0]   dsum_s_s;
    logic             last_s;
    logic [WIDTH:0]   nps_p_s;
    logic [WIDTH:0]   nps_s_s;

    // Digit slice, both copies' digit sums and the next partial sums.
    always_comb begin
        shamt_s  = 32'(cnt_r) * 32'(DIGIT);
        a_dig_s  = DIGIT'(a_r >> shamt_s);
        b_dig_s  = DIGIT'(b_r >> shamt_s);
        dsum_p_s = digit_add(a_dig_s, b_dig_s, c_p_r);
        // The injection flips only the shadow copy's low sum bit, never its carry.
        dsum_s_s = digit_add(a_dig_s, b_dig_s, c_s_r) ^ (DIGIT+1)'(inj_en);
        last_s   = (cnt_r == LAST_CNT);
        // Partial sums are cleared per attempt, so each digit is OR-ed into place.
        nps_p_s  = ps_p_r | ((WIDTH+1)'(dsum_p_s[DIGIT-1:0]) << shamt_s);
        nps_s_s  = ps_s_r | ((WIDTH+1)'(dsum_s_s[DIGIT-1:0]) << shamt_s);
        if (last_s) begin
            nps_p_s[WIDTH] = dsum_p_s[DIGIT];
            nps_s_s[WIDTH] = dsum_s_s[DIGIT];
        end else begin
            nps_p_s[WIDTH] = 1'b0;
            nps_s_s[WIDTH] = 1'b0;
        end
    end

    // Control FSM, both datapath copies and the held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            c_p_r       <= 1'b0;
            c_s_r       <= 1'b0;
            ps_p_r      <= {(WIDTH+1){1'b0}};
            ps_s_r      <= {(WIDTH+1){1'b0}};
            sum_r       <= {(WIDTH+1){1'b0}};
            fault_r     <= 1'b0;
            retries_r   <= 3'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r       <= a;
                        b_r       <= b;
                        cnt_r     <= {CW{1'b0}};
                        c_p_r     <= 1'b0;
                        c_s_r     <= 1'b0;
                        ps_p_r    <= {(WIDTH+1){1'b0}};
                        ps_s_r    <= {(WIDTH+1){1'b0}};
                        retries_r <= 3'd0;
                        fault_r   <= 1'b0;
                        state_r   <= RUN;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                RUN: begin
                    c_p_r  <= dsum_p_s[DIGIT];
                    c_s_r  <= dsum_s_s[DIGIT];
                    ps_p_r <= nps_p_s;
                    ps_s_r <= nps_s_s;
                    if (last_s) begin
                        state_r <= CHECK;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                CHECK: begin
                    if (ps_p_r == ps_s_r) begin
                        sum_r       <= ps_p_r;
                        fault_r     <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else if (retries_r < MAX_R) begin
                        // Recompute from the captured operands, not the live inputs.
                        retries_r <= retries_r + 3'd1;
                        cnt_r     <= {CW{1'b0}};
                        c_p_r     <= 1'b0;
                        c_s_r     <= 1'b0;
                        ps_p_r    <= {(WIDTH+1){1'b0}};
                        ps_s_r    <= {(WIDTH+1){1'b0}};
                        state_r   <= RUN;
                    end else begin
                        sum_r       <= ps_p_r;
                        fault_r     <= 1'b1;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst so it reads low for the whole reset cycle,
    // yet is high straight after the final reset edge.
    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign fault     = fault_r;
    assign retries   = retries_r;

endmodule

// File: tb/tb_addr_nu_serial_dmr.sv
// Self-checking bench for addr_nu_serial_dmr.
// dut0: WIDTH=4, DIGIT=1, MAX_RETRY=2, checked every cycle against a
//       transaction-level model plus directed literal expectations.
// dut1: WIDTH=8, DIGIT=4, directed and random operand pairs.
`timescale 1ns/1ps

module tb_addr_nu_serial_dmr;

    localparam int N0 = 4;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid  = 1'b0;
    logic [3:0] a         = 4'd0;
    logic [3:0] b         = 4'd0;
    logic       out_ready = 1'b1;
    logic       inj_en    = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] sum;
    logic       fault;
    logic [2:0] retries;

    logic       in_valid1  = 1'b0;
    logic [7:0] a1         = 8'd0;
    logic [7:0] b1         = 8'd0;
    logic       out_ready1 = 1'b1;
    logic       inj_en1    = 1'b0;
    logic       in_ready1;
    logic       out_valid1;
    logic [8:0] sum1;
    logic       fault1;
    logic [2:0] retries1;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt     = 0;
    bit chk_en   = 1'b0;

    // transaction-level model state for dut0
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_fault = 1'b0;
    bit m_bad   = 1'b0;
    int m_att   = 0;
    int m_t0    = 0;
    int m_sum   = 0;
    int m_rel   = 0;

    addr_nu_serial_dmr #(.WIDTH(4), .DIGIT(1), .MAX_RETRY(2)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .fault(fault), .retries(retries), .inj_en(inj_en)
    );

    addr_nu_serial_dmr #(.WIDTH(8), .DIGIT(4), .MAX_RETRY(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .fault(fault1), .retries(retries1), .inj_en(inj_en1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Model: an attempt takes N0 RUN edges then one CHECK edge; an attempt is
    // corrupted if inj_en was high on any of its RUN edges.
    initial begin
        forever begin
            @(posedge clk);
            ecnt++;
            if (rst) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1;
                    m_done = 1'b0;
                    m_t0   = ecnt;
                    m_att  = 0;
                    m_bad  = 1'b0;
                    m_sum  = int'(a) + int'(b);
                end
            end else if (m_done) begin
                if (out_ready) begin
                    m_busy = 1'b0;
                    m_done = 1'b0;
                end
            end else begin
                m_rel = ecnt - m_t0 - m_att * (N0 + 1);
                if (m_rel >= 1 && m_rel <= N0) begin
                    if (inj_en) m_bad = 1'b1;
                end else if (m_rel == N0 + 1) begin
                    if (!m_bad) begin
                        m_done  = 1'b1;
                        m_fault = 1'b0;
                    end else if (m_att < MR) begin
                        m_att++;
                        m_bad = 1'b0;
                    end else begin
                        m_done  = 1'b1;
                        m_fault = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of dut0 against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready", in_ready, !m_busy && !rst);
                check("out_valid", out_valid, m_done);
                if (m_done) begin
                    check("sum", sum, m_sum);
                    check("fault", fault, m_fault);
                    check("retries", retries, m_att);
                end
            end
        end
    end

    // mode: 0 none, 1 one-cycle pulse in first RUN cycle, 2 held, 3 high only while idle
    task automatic txn0(input logic [3:0] ta, input logic [3:0] tb, input int mode,
                        input int hold, input int want_sum, input int want_fault,
                        input int want_ret, input int want_lat, input string tag);
        int t0;
        int lat;
        bit seen;
        @(posedge clk); #2;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        inj_en    = (mode == 2 || mode == 3);
        @(posedge clk); #2;
        t0       = ecnt;
        in_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        if (mode == 3) inj_en = 1'b0;
        if (mode == 1) begin
            inj_en = 1'b1;
            @(posedge clk); #2;
            inj_en = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, seen, 1);
        lat = ecnt + 1 - t0;
        check({tag, "_latency"}, lat, want_lat);
        check({tag, "_sum"}, sum, want_sum);
        check({tag, "_fault"}, fault, want_fault);
        check({tag, "_retries"}, retries, want_ret);
        inj_en = 1'b0;
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, "_held_valid"}, out_valid, 1);
                check({tag, "_held_sum"}, sum, want_sum);
                check({tag, "_held_in_ready"}, in_ready, 0);
            end
            @(posedge clk); #2;
            out_ready = 1'b1;
        end
        @(posedge clk); #2;
        @(negedge clk);
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
    endtask

    task automatic txn1(input logic [7:0] ta, input logic [7:0] tb, input bit inj,
                        input int want_sum, input int want_fault, input int want_ret,
                        input int want_lat, input string tag);
        int t0;
        int lat;
        bit seen;
        @(posedge clk); #2;
        in_valid1 = 1'b1;
        a1        = ta;
        b1        = tb;
        inj_en1   = inj;
        @(posedge clk); #2;
        t0        = ecnt;
        in_valid1 = 1'b0;
        a1        = 8'($urandom);
        b1        = 8'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (out_valid1 === 1'b1) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, seen, 1);
        lat = ecnt + 1 - t0;
        check({tag, "_latency"}, lat, want_lat);
        check({tag, "_sum"}, sum1, want_sum);
        check({tag, "_fault"}, fault1, want_fault);
        check({tag, "_retries"}, retries1, want_ret);
        inj_en1 = 1'b0;
        @(posedge clk); #2;
        @(negedge clk);
        check({tag, "_idle_ready"}, in_ready1, 1);
    endtask

    initial begin
        bit seen;
        // reset state
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready0", in_ready, 0);
        check("rst_in_ready1", in_ready1, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after0", in_ready, 1);
        check("rst_valid0", out_valid, 0);
        check("rst_sum0", sum, 0);
        check("rst_fault0", fault, 0);
        check("rst_retries0", retries, 0);
        check("rst_ready_after1", in_ready1, 1);
        check("rst_sum1", sum1, 0);
        chk_en = 1'b1;

        // directed dut0 cases with hand-computed expectations
        txn0(4'd15, 4'd15, 0, 0, 30, 0, 0, 6, "max");
        txn0(4'd9, 4'd3, 1, 0, 12, 0, 1, 11, "pulse");
        txn0(4'd5, 4'd6, 2, 0, 11, 1, 2, 16, "held");
        txn0(4'd8, 4'd8, 0, 5, 16, 0, 0, 6, "hold");
        txn0(4'd0, 4'd0, 3, 0, 0, 0, 0, 6, "idle_inj");

        // reset in the middle of an operation
        @(posedge clk); #2;
        in_valid = 1'b1;
        a = 4'd7;
        b = 4'd6;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", in_ready, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("post_rst_no_valid", seen, 0);
        txn0(4'd1, 4'd2, 0, 0, 3, 0, 0, 6, "post_rst");

        // random traffic on dut0, checked by the per-cycle compare process
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = 4'($urandom);
            b         = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            inj_en    = ($urandom_range(0, 6) == 0);
        end
        @(posedge clk); #2;
        in_valid  = 1'b0;
        inj_en    = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;

        // dut1: WIDTH=8, DIGIT=4
        txn1(8'd200, 8'd100, 1'b0, 300, 0, 0, 4, "w8_200_100");
        txn1(8'd255, 8'd255, 1'b0, 510, 0, 0, 4, "w8_max");
        txn1(8'd0, 8'd0, 1'b0, 0, 0, 0, 4, "w8_zero");
        txn1(8'd255, 8'd255, 1'b1, 510, 1, 2, 10, "w8_inj");
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'($urandom);
            y = 8'($urandom);
            txn1(x, y, 1'b0, int'(x) + int'(y), 0, 0, 4, "w8_rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
